div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
- Sequencing and arbitration controller for a shared iterative unsigned divider. It computes dividend / divisor into a quotient and remainder.
- Two requesters compete for the single divider datapath. Each request is accepted through a valid/ready handshake, computed by restoring division at one quotient bit per clock, and returned on one response channel tagged with the requester ID.
- Sits between requesting blocks and the arithmetic. It replaces the combinational subtract loop with a bounded, fixed-latency sequential engine.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 pair accepted this cycle
- req0_dividend  input  WIDTH  requester 0 dividend
- req0_divisor  input  WIDTH  requester 0 divisor
- req1_valid  input  1  requester 1 has an operand pair
- req1_ready  output  1  requester 1 pair accepted this cycle
- req1_dividend  input  WIDTH  requester 1 dividend
- req1_divisor  input  WIDTH  requester 1 divisor
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_id  output  1  requester that owns the result
- rsp_quotient  output  WIDTH  quotient
- rsp_remainder  output  WIDTH  remainder
- rsp_div_zero  output  1  divisor was zero
- busy  output  1  state is not IDLE

Behaviour:
- One clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - State = IDLE.
  - rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero, busy = 0.
  - Round-robin pointer last = 1, so req0 wins first.
- States: IDLE, CALC, DONE.
- IDLE:
  - grant = req0 if only req0_valid, req1 if only req1_valid.
  - If both are valid, grant goes to the requester not equal to last.
  - reqN_ready = (state==IDLE) & grantN. It is combinational, and at most one ready is high per cycle.
  - Handshake (valid & ready) at the clock edge:
    - capture dividend and divisor, set rsp_id = granted ID, set last = granted ID;
    - go to CALC, or go straight to DONE if divisor == 0.
  - With no valid request, stay in IDLE and assert no ready.
- CALC (restoring division, MSB first):
  - WIDTH+1-bit partial remainder pr, reset to 0 at acceptance.
  - Shift register q is loaded with the dividend at acceptance.
  - Each cycle: t = {pr[WIDTH-1:0], q[WIDTH-1]}.
    - If t >= {0, divisor}: pr = t - divisor and shift a 1 into q.
    - Otherwise: pr = t and shift a 0 into q.
  - A bit counter counts WIDTH iterations, then the block goes to DONE with rsp_quotient = q and rsp_remainder = pr[WIDTH-1:0].
- DONE:
  - rsp_valid = 1, and all rsp_* outputs are held stable until rsp_ready = 1.
  - On rsp_valid & rsp_ready: go to IDLE and drop rsp_valid next cycle.
  - A new request may be accepted in the cycle after the response handshake, not in the same cycle.
- Latency, with acceptance in cycle 0:
  - nonzero divisor: CALC occupies cycles 1..WIDTH and rsp_valid first rises in cycle WIDTH+1;
  - zero divisor: rsp_valid rises in cycle 1.
- Throughput: one division per WIDTH+2 cycles minimum.
- Divide by zero: rsp_quotient = all ones, rsp_remainder = dividend, rsp_div_zero = 1. rsp_div_zero = 0 for every other result.
- Dividend < divisor: quotient = 0, remainder = dividend.
- Input changes on a requester that has not handshaken have no effect. Captured operands are immune to input changes after acceptance.
- Reset mid-operation (CALC or DONE): the in-flight division is discarded with no response. Everything returns to reset values on the next edge.
- rsp_ready high while not in DONE is ignored.

Optional Feature:
- Macro DIV_SHARE_STATS_EN.
- When defined:
  - Two extra outputs, stat_ops[7:0] and stat_dz[7:0].
  - stat_ops counts completed response handshakes; stat_dz counts those with rsp_div_zero = 1.
  - Both saturate at 255, are cleared by reset, and update on the edge of the response handshake.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- req0 13/3 with WIDTH=4 and rsp_ready held 1 -> rsp_valid in cycle 5 after accept, quotient 4, remainder 1, id 0, div_zero 0, busy high cycles 1..5.
- req1 7/0 -> rsp_valid in cycle 1 after accept, quotient 15, remainder 7, div_zero 1, id 1.
- Both valid from reset, req0 12/5 and req1 15/1 -> req0 accepted first (q2 r2, id 0), then req1 (q15 r0, id 1). A following simultaneous pair is granted to req0 again, because last = 1 after req1 was served.
- req0 2/9 with rsp_ready held low 10 cycles after rsp_valid -> outputs stable q0 r2 throughout, no req ready during the hold, IDLE the cycle after rsp_ready rises.
- Accept 15/2, assert rst_n = 0 in cycle 2 of CALC -> no rsp_valid, all outputs 0 next edge. A fresh request 9/4 afterward yields q2 r1.
- DIV_SHARE_STATS_EN defined: 3 normal divisions and 2 divide-by-zero -> stat_ops 5, stat_dz 2. 300 divisions -> stat_ops holds 255.

Source files
------------

// File: rtl/div_share_ctrl_if.sv
// +----------------------------------------------------------------------+
// | Module      : div_share_ctrl_if                                       |
// | Description : Request/response bundle for the shared divider          |
// |               controller (two requesters, one tagged response).      |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface div_share_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_dividend;
  logic [WIDTH-1:0] req0_divisor;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_dividend;
  logic [WIDTH-1:0] req1_divisor;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic             rsp_div_zero;
  logic             busy;

  // Requester / consumer side
  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero,
    input  busy
  );

  // Divider controller side
  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/div_share_ctrl.sv
// +----------------------------------------------------------------------+
// | Module      : div_share_ctrl                                          |
// | Description : Round-robin arbiter plus restoring divider sequencer,  |
// |               one quotient bit per clock, shared by two requesters.  |
// |               Optional macro DIV_SHARE_STATS_EN adds saturating      |
// |               stat_ops / stat_dz response counters.                  |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module div_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  div_share_ctrl_if.slave    bus
`ifdef DIV_SHARE_STATS_EN
  ,
  output logic [7:0]         stat_ops,
  output logic [7:0]         stat_dz
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             last;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic             rsp_div_zero;

  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH:0]   pr_next;
  logic [WIDTH-1:0] q_next;
  logic             rsp_hs;

  // Round-robin grant: a lone requester wins, a tie goes away from last.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept       = (state == IDLE) && grant_valid;
  assign sel_dividend = grant_id ? bus.req1_dividend : bus.req0_dividend;
  assign sel_divisor  = grant_id ? bus.req1_divisor  : bus.req0_divisor;
  assign rsp_hs       = (state == DONE) && bus.rsp_ready;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    t       = {pr[WIDTH-1:0], q[WIDTH-1]};
    ge      = (t >= {1'b0, dvsr});
    pr_next = ge ? (t - {1'b0, dvsr}) : t;
    q_next  = {q[WIDTH-2:0], ge};
  end

  // Sequencer: accept, iterate WIDTH times, hold the result until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      pr            <= '0;
      q             <= '0;
      dvsr          <= '0;
      cnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= grant_id;
            last   <= grant_id;
            pr     <= '0;
            q      <= sel_dividend;
            dvsr   <= sel_divisor;
            cnt    <= '0;
            if (sel_divisor == '0) begin
              // Divide by zero skips the iteration entirely.
              rsp_quotient  <= '1;
              rsp_remainder <= sel_dividend;
              rsp_div_zero  <= 1'b1;
              rsp_valid     <= 1'b1;
              state         <= DONE;
            end else begin
              rsp_div_zero <= 1'b0;
              state        <= CALC;
            end
          end
        end
        CALC: begin
          pr  <= pr_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            rsp_quotient  <= q_next;
            rsp_remainder <= pr_next[WIDTH-1:0];
            rsp_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_SHARE_STATS_EN
  // Saturating counts of delivered responses and of divide-by-zero ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_dz  <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != 8'hFF) begin
        stat_ops <= stat_ops + 8'd1;
      end
      if (rsp_div_zero && (stat_dz != 8'hFF)) begin
        stat_dz <= stat_dz + 8'd1;
      end
    end
  end
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

  assign bus.req0_ready    = accept && !grant_id;
  assign bus.req1_ready    = accept &&  grant_id;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_id        = rsp_id;
  assign bus.rsp_quotient  = rsp_quotient;
  assign bus.rsp_remainder = rsp_remainder;
  assign bus.rsp_div_zero  = rsp_div_zero;
  assign bus.busy          = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
// +----------------------------------------------------------------------+
// | Module      : tb_div_share_ctrl                                       |
// | Description : Directed self-checking bench for div_share_ctrl        |
// |               (WIDTH = 4). Stats checks apply when                   |
// |               DIV_SHARE_STATS_EN is defined.                          |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_div_share_ctrl;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  div_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

`ifdef DIV_SHARE_STATS_EN
  logic [7:0] stat_ops;
  logic [7:0] stat_dz;
`endif

  div_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DIV_SHARE_STATS_EN
    ,
    .stat_ops (stat_ops),
    .stat_dz  (stat_dz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid    = 1'b0;
    bus.req1_valid    = 1'b0;
    bus.req0_dividend = '0;
    bus.req0_divisor  = '0;
    bus.req1_dividend = '0;
    bus.req1_divisor  = '0;
    bus.rsp_ready     = 1'b0;
  endtask

  // Present requests, confirm the grant, then follow the division to its response.
  task automatic run(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                     input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                     input logic exp_id, input logic [3:0] exp_q, input logic [3:0] exp_r,
                     input logic exp_dz, input int exp_lat, input int hold);
    int lat;
    tick();
    bus.req0_valid    = v0;
    bus.req0_dividend = a0;
    bus.req0_divisor  = b0;
    bus.req1_valid    = v1;
    bus.req1_dividend = a1;
    bus.req1_divisor  = b1;
    #1;
    check("req0_ready_grant", bus.req0_ready, exp_id == 1'b0);
    check("req1_ready_grant", bus.req1_ready, exp_id == 1'b1);
    tick();
    // Scramble the inputs after acceptance; captured operands must not care.
    bus.req0_valid    = 1'b0;
    bus.req1_valid    = 1'b0;
    bus.req0_dividend = ~a0;
    bus.req0_divisor  = ~b0;
    bus.req1_dividend = ~a1;
    bus.req1_divisor  = ~b1;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      check("busy_calc", bus.busy, 1);
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_done", bus.busy, 1);
    for (int i = 0; i < hold; i++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_quot", bus.rsp_quotient, exp_q);
      check("hold_rem", bus.rsp_remainder, exp_r);
      check("hold_ready0", bus.req0_ready, 0);
      check("hold_ready1", bus.req1_ready, 0);
      tick();
    end
    check("rsp_id", bus.rsp_id, exp_id);
    check("rsp_quotient", bus.rsp_quotient, exp_q);
    check("rsp_remainder", bus.rsp_remainder, exp_r);
    check("rsp_div_zero", bus.rsp_div_zero, exp_dz);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("idle_after_hs", bus.busy, 0);
    check("valid_dropped", bus.rsp_valid, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    do_reset();

    check("rst_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_quot", bus.rsp_quotient, 0);
    check("rst_rem", bus.rsp_remainder, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_dz", bus.rsp_div_zero, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);

    // rsp_ready asserted outside DONE has no effect.
    bus.rsp_ready = 1'b1;
    tick();
    check("stray_ready_busy", bus.busy, 0);
    bus.rsp_ready = 1'b0;

    // 13/3 on req0, then 7/0 on req1
    run(1, 4'd13, 4'd3, 0, 4'd0, 4'd0, 1'b0, 4'd4, 4'd1, 1'b0, 5, 0);
    run(0, 4'd0, 4'd0, 1, 4'd7, 4'd0, 1'b1, 4'd15, 4'd7, 1'b1, 1, 0);

    // Tie from reset: req0 first, then req1, then req0 again
    do_reset();
    run(1, 4'd12, 4'd5, 1, 4'd15, 4'd1, 1'b0, 4'd2, 4'd2, 1'b0, 5, 0);
    run(0, 4'd12, 4'd5, 1, 4'd15, 4'd1, 1'b1, 4'd15, 4'd0, 1'b0, 5, 0);
    run(1, 4'd11, 4'd4, 1, 4'd6, 4'd3, 1'b0, 4'd2, 4'd3, 1'b0, 5, 0);
    // Next tie goes to req1 since last = 0
    run(1, 4'd11, 4'd4, 1, 4'd6, 4'd3, 1'b1, 4'd2, 4'd0, 1'b0, 5, 0);

    // Dividend smaller than divisor, response back-pressured 10 cycles
    run(1, 4'd2, 4'd9, 0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd2, 1'b0, 5, 10);
    // Boundaries: 15/1, 15/15, 0/0
    run(1, 4'd15, 4'd1, 0, 4'd0, 4'd0, 1'b0, 4'd15, 4'd0, 1'b0, 5, 0);
    run(0, 4'd0, 4'd0, 1, 4'd15, 4'd15, 1'b1, 4'd1, 4'd0, 1'b0, 5, 0);
    run(1, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1'b0, 4'd15, 4'd0, 1'b1, 1, 0);

    // Reset in the second CALC cycle discards the division
    tick();
    bus.req0_valid    = 1'b1;
    bus.req0_dividend = 4'd15;
    bus.req0_divisor  = 4'd2;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_valid", bus.rsp_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_quot", bus.rsp_quotient, 0);
    check("midrst_rem", bus.rsp_remainder, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_rsp", bus.rsp_valid, 0);
    end
    run(1, 4'd9, 4'd4, 0, 4'd0, 4'd0, 1'b0, 4'd2, 4'd1, 1'b0, 5, 0);

`ifdef DIV_SHARE_STATS_EN
    do_reset();
    check("stat_ops_rst", stat_ops, 0);
    check("stat_dz_rst", stat_dz, 0);
    run(1, 4'd13, 4'd3, 0, 4'd0, 4'd0, 1'b0, 4'd4, 4'd1, 1'b0, 5, 0);
    run(1, 4'd5, 4'd0, 0, 4'd0, 4'd0, 1'b0, 4'd15, 4'd5, 1'b1, 1, 0);
    run(1, 4'd9, 4'd4, 0, 4'd0, 4'd0, 1'b0, 4'd2, 4'd1, 1'b0, 5, 0);
    run(1, 4'd3, 4'd0, 0, 4'd0, 4'd0, 1'b0, 4'd15, 4'd3, 1'b1, 1, 0);
    run(1, 4'd8, 4'd8, 0, 4'd0, 4'd0, 1'b0, 4'd1, 4'd0, 1'b0, 5, 0);
    check("stat_ops_5", stat_ops, 5);
    check("stat_dz_2", stat_dz, 2);
    for (int i = 0; i < 300; i++) begin
      run(1, 4'd6, 4'd0, 0, 4'd0, 4'd0, 1'b0, 4'd15, 4'd6, 1'b1, 1, 0);
    end
    check("stat_ops_sat", stat_ops, 255);
    check("stat_dz_sat", stat_dz, 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
